// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH iterations per operation.
// Results are registered on completion and held until the next operation finishes.
`timescale 1ns/1ps
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divzero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH-1:0] prem_reg;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             borrow;
    logic             trial_unused;
    logic [WIDTH-1:0] prem_next;
    logic [WIDTH-1:0] dvd_next;

    // The top bit of the subtraction is the borrow (inverted carry-out).
    function automatic logic [WIDTH+1:0] trial_sub(input logic [WIDTH:0]   a,
                                                   input logic [WIDTH-1:0] b);
        trial_sub = {1'b0, a} - {2'b00, b};
    endfunction

    // Partial remainder stays below the divisor, so a kept difference always fits WIDTH bits.
    always_comb begin
        shifted      = {prem_reg, dvd_reg[WIDTH-1]};
        trial        = trial_sub(shifted, dvs_reg);
        borrow       = trial[WIDTH+1];
        trial_unused = trial[WIDTH];
        prem_next    = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_next     = {dvd_reg[WIDTH-2:0], ~borrow};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            count     <= '0;
            dvd_reg   <= '0;
            dvs_reg   <= '0;
            prem_reg  <= '0;
            quotient  <= '0;
            remainder <= '0;
            divzero   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dvd_reg  <= dividend;
                        dvs_reg  <= divisor;
                        prem_reg <= '0;
                        if (divisor == '0) begin
                            // Division by zero bypasses the iterations entirely.
                            count     <= '0;
                            quotient  <= '1;
                            remainder <= dividend;
                            divzero   <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            count <= CNT_W'(WIDTH);
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    prem_reg <= prem_next;
                    dvd_reg  <= dvd_next;
                    count    <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        quotient  <= dvd_next;
                        remainder <= prem_next;
                        divzero   <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed scenarios plus a random sweep against integer division.
`timescale 1ns/1ps
module tb_seq_divider;

    localparam int W = 8;

    logic         clk;
    logic         resetn;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         divzero;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .divzero  (divzero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one operation and checks timing and results against plain integer division.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int           cyc;
        int           busy_cyc;
        int           both;
        int           changed;
        logic [W-1:0] eq, er, q0, r0;
        logic         ez, z0;
        if (b == 0) begin
            eq = '1; er = a; ez = 1'b1;
        end else begin
            eq = W'(int'(a) / int'(b)); er = W'(int'(a) % int'(b)); ez = 1'b0;
        end
        @(negedge clk);
        q0 = quotient; r0 = remainder; z0 = divzero;
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk);
        #1;
        start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
        cyc = 0; busy_cyc = 0; both = 0; changed = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy && done) both++;
            if (done) break;
            if (busy) busy_cyc++;
            if (quotient !== q0 || remainder !== r0 || divzero !== z0) changed++;
        end
        chk("latency", cyc, (b == 0) ? 1 : W + 1);
        chk("busy_cycles", busy_cyc, (b == 0) ? 0 : W);
        chk("busy_done_overlap", both, 0);
        chk("no_intermediate", changed, 0);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("divzero", divzero, ez);
        @(negedge clk);
        chk("done_drop", done, 0);
        chk("quotient_hold", quotient, eq);
    endtask

    initial begin
        int           cyc;
        int           n;
        logic [W-1:0] a, b;

        resetn = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_divzero", divzero, 0);

        start = 1'b1; dividend = 8'd10; divisor = 8'd3;
        @(posedge clk);
        #1;
        chk("rst_start_ignored_busy", busy, 0);
        chk("rst_start_ignored_done", done, 0);
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        do_op(8'd100, 8'd7);
        do_op(8'd255, 8'd1);
        do_op(8'd5, 8'd9);
        do_op(8'd0, 8'd3);
        do_op(8'd200, 8'd0);
        do_op(8'd9, 8'd3);

        // Start held through a whole operation, operands changed mid-run.
        @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
        @(posedge clk);
        #1;
        cyc = 0;
        repeat (2) begin @(negedge clk); cyc++; end
        dividend = 8'd99; divisor = 8'd2;
        while (!done && cyc < 40) begin @(negedge clk); cyc++; end
        chk("held_latency", cyc, W + 1);
        chk("held_quotient", quotient, 10);
        chk("held_remainder", remainder, 0);
        chk("held_divzero", divzero, 0);
        @(negedge clk);
        chk("held_gap_busy", busy, 0);
        chk("held_gap_done", done, 0);
        @(negedge clk);
        chk("held_restart_busy", busy, 1);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin @(negedge clk); cyc++; end
        chk("held2_latency", cyc, W + 1);
        chk("held2_quotient", quotient, 49);
        chk("held2_remainder", remainder, 1);
        @(negedge clk);

        // Asynchronous reset pulse in the middle of an operation.
        @(negedge clk);
        start = 1'b1; dividend = 8'd77; divisor = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        #1 resetn = 1'b0;
        #0.5;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_quotient", quotient, 0);
        chk("async_rst_remainder", remainder, 0);
        chk("async_rst_divzero", divzero, 0);
        #0.5 resetn = 1'b1;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) n++;
        end
        chk("aborted_no_activity", n, 0);
        do_op(8'd17, 8'd4);

        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom_range(0, 255));
            b = (i % 4 == 0) ? W'($urandom_range(1, 15)) : W'($urandom_range(1, 255));
            do_op(a, b);
            chk("identity",
                (int'(quotient) * int'(b) + int'(remainder) == int'(a)) && (remainder < b), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
